// File: rtl/bmd_wdma_desc_sched.sv
// Descriptor queue and run scheduler that feeds buffer descriptors to the BMD write-DMA engine.
// Optional build macro BMD_WDMA_SCHED_AUTORESTART_EN: re-arm automatically after an underrun halt.
module bmd_wdma_desc_sched #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_rst_i,
   input  logic                  desc_wr_i,
   input  logic [31:0]           desc_addr_i,
   input  logic [7:0]            desc_up_addr_i,
   input  logic [15:0]           desc_len_i,
   output logic                  desc_full_o,
   output logic [DEPTH_LOG2:0]   desc_count_o,
   input  logic                  sched_start_i,
   input  logic                  sched_stop_i,
   output logic                  wdma_init_rst_o,
   output logic                  wdma_start_o,
   output logic                  wdma_stop_o,
   output logic [31:0]           next_wdma_addr_o,
   output logic [7:0]            next_wdma_up_addr_o,
   output logic [15:0]           wdma_frame_len_o,
   output logic                  next_wdma_valid_o,
   input  logic                  wdma_irq_i,
   input  logic [3:0]            wdma_status_i,
   output logic [15:0]           done_cnt_o,
   output logic                  underrun_o,
   output logic                  overflow_o,
   output logic                  timeout_o,
   output logic                  halted_o
);
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [2:0] {IDLE, INIT, ARM, START, RUN, STAT, HALT} state_t;

   state_t                state;
   logic [55:0]           mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr, nxt_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic [55:0]           head, head_nxt;
   logic                  irq_q, preload_sent, push, pop, status_pop, irq_rise;
   logic                  has_desc, multi_desc, restart;

   assign nxt_ptr      = rd_ptr + 1'b1;
   assign head         = mem[rd_ptr];
   assign head_nxt     = mem[nxt_ptr];
   assign has_desc     = (count != '0);
   assign multi_desc   = (count[DEPTH_LOG2:1] != '0);
   assign push         = desc_wr_i && !init_rst_i && (count != FULL_CNT);
   assign status_pop   = (wdma_status_i == 4'b0001) || (wdma_status_i == 4'b0011);
   assign pop          = (state == STAT) && status_pop && has_desc && !init_rst_i;
   assign irq_rise     = wdma_irq_i && !irq_q;
   assign desc_count_o = count;
   assign desc_full_o  = (count == FULL_CNT);
   assign halted_o     = (state == HALT);

`ifdef BMD_WDMA_SCHED_AUTORESTART_EN
   logic rearm;
   assign restart = has_desc && (sched_start_i || ((state == HALT) && rearm));
`else
   assign restart = has_desc && sched_start_i;
`endif

   // Descriptor storage: {up_addr, addr, len}; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {desc_up_addr_i, desc_addr_i, desc_len_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE; rd_ptr <= '0; wr_ptr <= '0; count <= '0;
         irq_q <= 1'b0; preload_sent <= 1'b0;
         wdma_init_rst_o <= 1'b0; wdma_start_o <= 1'b0; wdma_stop_o <= 1'b0;
         next_wdma_valid_o <= 1'b0; next_wdma_addr_o <= '0; next_wdma_up_addr_o <= '0;
         wdma_frame_len_o <= '0; done_cnt_o <= '0;
         underrun_o <= 1'b0; overflow_o <= 1'b0; timeout_o <= 1'b0;
`ifdef BMD_WDMA_SCHED_AUTORESTART_EN
         rearm <= 1'b0;
`endif
      end else if (init_rst_i) begin
         state <= IDLE; rd_ptr <= '0; wr_ptr <= '0; count <= '0;
         irq_q <= 1'b0; preload_sent <= 1'b0;
         wdma_init_rst_o <= 1'b0; wdma_start_o <= 1'b0; wdma_stop_o <= 1'b0;
         next_wdma_valid_o <= 1'b0; next_wdma_addr_o <= '0; next_wdma_up_addr_o <= '0;
         wdma_frame_len_o <= '0; done_cnt_o <= '0;
         underrun_o <= 1'b0; overflow_o <= 1'b0; timeout_o <= 1'b0;
`ifdef BMD_WDMA_SCHED_AUTORESTART_EN
         rearm <= 1'b0;
`endif
      end else begin
         wdma_init_rst_o   <= 1'b0;
         wdma_start_o      <= 1'b0;
         wdma_stop_o       <= 1'b0;
         next_wdma_valid_o <= 1'b0;
         irq_q             <= wdma_irq_i;

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (desc_wr_i && !push) overflow_o <= 1'b1;
         if (pop) rd_ptr <= nxt_ptr;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;

         // Outputs are registered on the edge that enters the state they belong to.
         case (state)
            IDLE, HALT: begin
               if (restart) begin
                  state           <= INIT;
                  wdma_init_rst_o <= 1'b1;
                  preload_sent    <= 1'b0;
               end
            end
            INIT: begin
               state               <= ARM;
               next_wdma_valid_o   <= 1'b1;
               {next_wdma_up_addr_o, next_wdma_addr_o, wdma_frame_len_o} <= head;
            end
            ARM: begin
               state        <= START;
               wdma_start_o <= 1'b1;
            end
            START, RUN: begin
               if ((state == RUN) && sched_stop_i) wdma_stop_o <= 1'b1;
               if ((state == RUN) && irq_rise) begin
                  state <= STAT;
               end else begin
                  state <= RUN;
                  // Preload the following buffer so the engine can chain without a gap.
                  if (multi_desc && !preload_sent) begin
                     preload_sent      <= 1'b1;
                     next_wdma_valid_o <= 1'b1;
                     {next_wdma_up_addr_o, next_wdma_addr_o, wdma_frame_len_o} <= head_nxt;
                  end
               end
            end
            STAT: begin
`ifdef BMD_WDMA_SCHED_AUTORESTART_EN
               rearm <= (wdma_status_i == 4'b0011);
`endif
               case (wdma_status_i)
                  4'b0001: begin
                     done_cnt_o   <= done_cnt_o + 1'b1;
                     preload_sent <= 1'b0;
                     state        <= RUN;
                  end
                  4'b0011: begin
                     done_cnt_o <= done_cnt_o + 1'b1;
                     underrun_o <= 1'b1;
                     state      <= HALT;
                  end
                  4'b0010, 4'b0100: state <= HALT;
                  default: begin
                     timeout_o <= 1'b1;
                     state     <= HALT;
                  end
               endcase
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bmd_wdma_desc_sched.sv
// Self-checking bench for bmd_wdma_desc_sched: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_bmd_wdma_desc_sched;
   logic        clk = 1'b0;
   logic        rst_n, init_rst_i, desc_wr_i, sched_start_i, sched_stop_i, wdma_irq_i;
   logic [31:0] desc_addr_i;
   logic [7:0]  desc_up_addr_i;
   logic [15:0] desc_len_i;
   logic [3:0]  wdma_status_i;
   logic        desc_full_o, wdma_init_rst_o, wdma_start_o, wdma_stop_o, next_wdma_valid_o;
   logic [2:0]  desc_count_o;
   logic [31:0] next_wdma_addr_o;
   logic [7:0]  next_wdma_up_addr_o;
   logic [15:0] wdma_frame_len_o, done_cnt_o;
   logic        underrun_o, overflow_o, timeout_o, halted_o;

   bmd_wdma_desc_sched #(.DEPTH_LOG2(2)) dut (
      .clk(clk), .rst_n(rst_n), .init_rst_i(init_rst_i), .desc_wr_i(desc_wr_i),
      .desc_addr_i(desc_addr_i), .desc_up_addr_i(desc_up_addr_i), .desc_len_i(desc_len_i),
      .desc_full_o(desc_full_o), .desc_count_o(desc_count_o),
      .sched_start_i(sched_start_i), .sched_stop_i(sched_stop_i),
      .wdma_init_rst_o(wdma_init_rst_o), .wdma_start_o(wdma_start_o), .wdma_stop_o(wdma_stop_o),
      .next_wdma_addr_o(next_wdma_addr_o), .next_wdma_up_addr_o(next_wdma_up_addr_o),
      .wdma_frame_len_o(wdma_frame_len_o), .next_wdma_valid_o(next_wdma_valid_o),
      .wdma_irq_i(wdma_irq_i), .wdma_status_i(wdma_status_i), .done_cnt_o(done_cnt_o),
      .underrun_o(underrun_o), .overflow_o(overflow_o), .timeout_o(timeout_o),
      .halted_o(halted_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event log of the pulses the DUT issues, sampled mid-cycle.
   int          valid_cyc[$], init_cyc[$], start_cyc[$], stop_cyc[$];
   logic [55:0] valid_desc[$];
   always @(negedge clk) begin
      if (next_wdma_valid_o) begin
         valid_cyc.push_back(cyc);
         valid_desc.push_back({next_wdma_up_addr_o, next_wdma_addr_o, wdma_frame_len_o});
      end
      if (wdma_init_rst_o) init_cyc.push_back(cyc);
      if (wdma_start_o) start_cyc.push_back(cyc);
      if (wdma_stop_o) stop_cyc.push_back(cyc);
   end

   // Reference model: queue contents, completion count, sticky flags, run/halt status.
   logic [55:0] mq[$];
   int          m_done;
   bit          m_over, m_under, m_tmo, m_run, m_halt;
   int          n_pass = 0, n_total = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon;
      valid_cyc.delete(); valid_desc.delete(); init_cyc.delete();
      start_cyc.delete(); stop_cyc.delete();
   endtask

   task automatic model_reset;
      mq.delete(); m_done = 0; m_over = 0; m_under = 0; m_tmo = 0; m_run = 0; m_halt = 0;
   endtask

   function automatic logic [55:0] rand_desc();
      logic [7:0]  u;
      logic [31:0] a;
      logic [15:0] l;
      u = 8'($urandom);
      a = $urandom;
      l = 16'($urandom);
      return {u, a, l};
   endfunction

   task automatic do_init_rst;
      init_rst_i = 1'b1;
      tick;
      init_rst_i = 1'b0;
      model_reset();
      clear_mon();
   endtask

   task automatic push_desc(input logic [55:0] d);
      {desc_up_addr_i, desc_addr_i, desc_len_i} = d;
      desc_wr_i = 1'b1;
      tick;
      desc_wr_i = 1'b0;
      if (mq.size() == 4) m_over = 1;
      else mq.push_back(d);
   endtask

   task automatic start_sched(output int t);
      t = cyc;
      sched_start_i = 1'b1;
      tick;
      sched_start_i = 1'b0;
      if (!m_run && mq.size() > 0) begin
         m_run = 1;
         m_halt = 0;
      end
   endtask

   // Status is wrong on the edge cycle and correct only on the following one.
   task automatic do_irq(input logic [3:0] s);
      wdma_irq_i = 1'b1;
      wdma_status_i = ~s;
      tick;
      wdma_status_i = s;
      tick;
      wdma_irq_i = 1'b0;
      wdma_status_i = 4'b0;
      tick;
      tick;
      case (s)
         4'b0001: begin void'(mq.pop_front()); m_done++; end
         4'b0011: begin void'(mq.pop_front()); m_done++; m_under = 1; m_run = 0; m_halt = 1; end
         4'b0010, 4'b0100: begin m_run = 0; m_halt = 1; end
         default: begin m_tmo = 1; m_run = 0; m_halt = 1; end
      endcase
   endtask

   task automatic test_reset;
      int t;
      n_total++; if (desc_count_o !== 3'd0 || desc_full_o !== 1'b0) $display("FAIL reset_count got=%0d/%0b exp=0/0", desc_count_o, desc_full_o); else n_pass++;
      n_total++; if ({underrun_o, overflow_o, timeout_o, halted_o} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {underrun_o, overflow_o, timeout_o, halted_o}); else n_pass++;
      n_total++; if ({next_wdma_up_addr_o, next_wdma_addr_o, wdma_frame_len_o, done_cnt_o} !== 72'd0) $display("FAIL reset_desc got=%0h exp=0", {next_wdma_up_addr_o, next_wdma_addr_o, wdma_frame_len_o}); else n_pass++;
      n_total++; if ({wdma_init_rst_o, wdma_start_o, wdma_stop_o, next_wdma_valid_o} !== 4'b0) $display("FAIL reset_pulses got=%b exp=0000", {wdma_init_rst_o, wdma_start_o, wdma_stop_o, next_wdma_valid_o}); else n_pass++;
      clear_mon();
      start_sched(t);
      repeat (4) tick;
      n_total++; if (init_cyc.size() != 0 || start_cyc.size() != 0) $display("FAIL empty_start got=%0d pulses exp=0", init_cyc.size() + start_cyc.size()); else n_pass++;
   endtask

   task automatic test_start_timing;
      int t;
      do_init_rst();
      push_desc({8'h00, 32'h0000_1000, 16'd4});
      push_desc({8'h00, 32'h0000_2000, 16'd4});
      clear_mon();
      start_sched(t);
      repeat (5) tick;
      n_total++; if (init_cyc.size() != 1 || init_cyc[0] != t + 1) $display("FAIL init_timing got n=%0d cyc=%0d exp n=1 cyc=%0d", init_cyc.size(), (init_cyc.size() > 0) ? init_cyc[0] : -1, t + 1); else n_pass++;
      n_total++; if (start_cyc.size() != 1 || start_cyc[0] != t + 3) $display("FAIL start_timing got n=%0d cyc=%0d exp n=1 cyc=%0d", start_cyc.size(), (start_cyc.size() > 0) ? start_cyc[0] : -1, t + 3); else n_pass++;
      n_total++; if (valid_cyc.size() != 2) $display("FAIL valid_count got=%0d exp=2", valid_cyc.size()); else n_pass++;
      if (valid_cyc.size() == 2) begin
         n_total++; if (valid_cyc[0] != t + 2 || valid_desc[0] !== {8'h00, 32'h1000, 16'd4}) $display("FAIL valid0 got cyc=%0d d=%0h exp cyc=%0d d=1000_0004", valid_cyc[0], valid_desc[0], t + 2); else n_pass++;
         n_total++; if (valid_cyc[1] != t + 4 || valid_desc[1] !== {8'h00, 32'h2000, 16'd4}) $display("FAIL valid1 got cyc=%0d d=%0h exp cyc=%0d d=2000_0004", valid_cyc[1], valid_desc[1], t + 4); else n_pass++;
      end
      n_total++; if (next_wdma_addr_o !== 32'h2000) $display("FAIL desc_hold got=%0h exp=2000", next_wdma_addr_o); else n_pass++;
      clear_mon();
      sched_stop_i = 1'b1;
      tick;
      sched_stop_i = 1'b0;
      repeat (2) tick;
      n_total++; if (stop_cyc.size() != 1 || halted_o !== 1'b0) $display("FAIL stop_pulse got n=%0d halted=%b exp n=1 halted=0", stop_cyc.size(), halted_o); else n_pass++;
   endtask

   task automatic test_overflow;
      int t;
      logic [55:0] d[5];
      do_init_rst();
      for (int i = 0; i < 5; i++) begin
         d[i] = rand_desc();
         push_desc(d[i]);
      end
      n_total++; if (desc_count_o !== 3'd4 || desc_full_o !== 1'b1 || overflow_o !== 1'b1) $display("FAIL overflow got cnt=%0d full=%b ovf=%b exp 4/1/1", desc_count_o, desc_full_o, overflow_o); else n_pass++;
      clear_mon();
      start_sched(t);
      repeat (4) tick;
      for (int i = 0; i < 4; i++) do_irq(4'b0001);
      n_total++; if (valid_desc.size() != 4) $display("FAIL ovf_presented got=%0d exp=4", valid_desc.size()); else n_pass++;
      for (int i = 0; i < 4 && i < valid_desc.size(); i++) begin
         n_total++; if (valid_desc[i] !== d[i]) $display("FAIL ovf_desc%0d got=%0h exp=%0h", i, valid_desc[i], d[i]); else n_pass++;
      end
      n_total++; if (done_cnt_o !== 16'(m_done) || desc_count_o !== 3'(mq.size()) || halted_o !== 1'b0) $display("FAIL ovf_drain got done=%0d cnt=%0d halt=%b exp %0d/%0d/0", done_cnt_o, desc_count_o, halted_o, m_done, mq.size()); else n_pass++;
      do_init_rst();
      n_total++; if (overflow_o !== 1'b0 || done_cnt_o !== 16'd0 || desc_count_o !== 3'd0) $display("FAIL init_rst_clear got ovf=%b done=%0d cnt=%0d exp 0/0/0", overflow_o, done_cnt_o, desc_count_o); else n_pass++;
   endtask

   task automatic test_underrun_halt;
      int t;
      do_init_rst();
      push_desc(rand_desc());
      push_desc(rand_desc());
      start_sched(t);
      repeat (4) tick;
      do_irq(4'b0001);
      do_irq(4'b0011);
      n_total++; if (done_cnt_o !== 16'd2 || underrun_o !== 1'b1 || halted_o !== 1'b1 || desc_count_o !== 3'd0) $display("FAIL underrun got done=%0d und=%b halt=%b cnt=%0d exp 2/1/1/0", done_cnt_o, underrun_o, halted_o, desc_count_o); else n_pass++;
      clear_mon();
      push_desc(rand_desc());
      repeat (5) tick;
`ifdef BMD_WDMA_SCHED_AUTORESTART_EN
      n_total++; if (init_cyc.size() != 1) $display("FAIL autorestart got=%0d exp=1", init_cyc.size()); else n_pass++;
      m_run = 1; m_halt = 0;
`else
      n_total++; if (init_cyc.size() != 0 || halted_o !== 1'b1) $display("FAIL no_autorestart got n=%0d halt=%b exp 0/1", init_cyc.size(), halted_o); else n_pass++;
      start_sched(t);
      repeat (4) tick;
      n_total++; if (init_cyc.size() != 1 || init_cyc[0] != t + 1 || halted_o !== 1'b0) $display("FAIL halt_restart got n=%0d halt=%b exp 1/0", init_cyc.size(), halted_o); else n_pass++;
`endif
   endtask

   task automatic test_timeout_restart;
      int t;
      logic [55:0] d0;
      do_init_rst();
      d0 = rand_desc();
      push_desc(d0);
      start_sched(t);
      repeat (4) tick;
      do_irq(4'b1000);
      n_total++; if (timeout_o !== 1'b1 || halted_o !== 1'b1 || desc_count_o !== 3'd1 || done_cnt_o !== 16'd0) $display("FAIL timeout got tmo=%b halt=%b cnt=%0d done=%0d exp 1/1/1/0", timeout_o, halted_o, desc_count_o, done_cnt_o); else n_pass++;
      push_desc(rand_desc());
      clear_mon();
      start_sched(t);
      repeat (4) tick;
      n_total++; if (init_cyc.size() != 1 || init_cyc[0] != t + 1) $display("FAIL tmo_restart got n=%0d exp init at %0d", init_cyc.size(), t + 1); else n_pass++;
      n_total++; if (halted_o !== 1'b0 || timeout_o !== 1'b1) $display("FAIL tmo_sticky got halt=%b tmo=%b exp 0/1", halted_o, timeout_o); else n_pass++;
      n_total++; if (valid_desc.size() == 0 || valid_desc[0] !== d0) $display("FAIL tmo_head got=%0h exp=%0h", (valid_desc.size() > 0) ? valid_desc[0] : 56'd0, d0); else n_pass++;
   endtask

   task automatic test_push_pop_same_cycle;
      int t;
      logic [55:0] d2;
      do_init_rst();
      push_desc(rand_desc());
      push_desc(rand_desc());
      start_sched(t);
      repeat (4) tick;
      d2 = rand_desc();
      wdma_irq_i = 1'b1;
      wdma_status_i = 4'b0001;
      tick;
      {desc_up_addr_i, desc_addr_i, desc_len_i} = d2;
      desc_wr_i = 1'b1;
      tick;
      desc_wr_i = 1'b0;
      wdma_irq_i = 1'b0;
      wdma_status_i = 4'b0;
      void'(mq.pop_front()); mq.push_back(d2); m_done++;
      n_total++; if (desc_count_o !== 3'd2) $display("FAIL push_pop_count got=%0d exp=2", desc_count_o); else n_pass++;
      repeat (2) tick;
      n_total++; if (done_cnt_o !== 16'(m_done) || halted_o !== 1'b0) $display("FAIL push_pop_done got=%0d halt=%b exp %0d/0", done_cnt_o, halted_o, m_done); else n_pass++;
   endtask

   task automatic test_async_reset;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if (desc_count_o !== 3'd0 || done_cnt_o !== 16'd0 || halted_o !== 1'b0) $display("FAIL async_cnt got cnt=%0d done=%0d halt=%b exp 0/0/0", desc_count_o, done_cnt_o, halted_o); else n_pass++;
      n_total++; if ({next_wdma_up_addr_o, next_wdma_addr_o, wdma_frame_len_o} !== 56'd0 || next_wdma_valid_o !== 1'b0) $display("FAIL async_desc got=%0h exp=0", {next_wdma_up_addr_o, next_wdma_addr_o, wdma_frame_len_o}); else n_pass++;
      #1;
      rst_n = 1'b1;
      model_reset();
      tick;
   endtask

   task automatic test_random;
      int t, k, r;
      logic [3:0] s;
      do_init_rst();
      for (int it = 0; it < 60; it++) begin
         if (!m_run) begin
            if (mq.size() == 0) begin
               k = $urandom_range(1, 3);
               for (int j = 0; j < k; j++) push_desc(rand_desc());
            end
            start_sched(t);
            repeat (4) tick;
         end else begin
            k = $urandom_range(0, 9);
            if (k < 2 || mq.size() == 0) push_desc(rand_desc());
            else if (k == 2) begin
               sched_stop_i = 1'b1;
               tick;
               sched_stop_i = 1'b0;
            end else begin
               r = $urandom_range(0, 7);
               case (r)
                  0, 1, 2, 3: s = 4'b0001;
                  4: s = 4'b0011;
                  5: s = ($urandom_range(0, 1) == 1) ? 4'b0010 : 4'b0100;
                  6: s = 4'b1000;
                  default: s = 4'($urandom_range(0, 15));
               endcase
               do_irq(s);
            end
         end
         n_total++; if (desc_count_o !== 3'(mq.size())) $display("FAIL rnd%0d_count got=%0d exp=%0d", it, desc_count_o, mq.size()); else n_pass++;
         n_total++; if (done_cnt_o !== 16'(m_done)) $display("FAIL rnd%0d_done got=%0d exp=%0d", it, done_cnt_o, m_done); else n_pass++;
         n_total++; if ({underrun_o, overflow_o, timeout_o} !== {m_under, m_over, m_tmo}) $display("FAIL rnd%0d_flags got=%b exp=%b", it, {underrun_o, overflow_o, timeout_o}, {m_under, m_over, m_tmo}); else n_pass++;
         n_total++; if (halted_o !== m_halt) $display("FAIL rnd%0d_halted got=%b exp=%b", it, halted_o, m_halt); else n_pass++;
      end
   endtask

   initial begin
      rst_n = 1'b0; init_rst_i = 1'b0; desc_wr_i = 1'b0; sched_start_i = 1'b0;
      sched_stop_i = 1'b0; wdma_irq_i = 1'b0; wdma_status_i = 4'b0;
      desc_addr_i = '0; desc_up_addr_i = '0; desc_len_i = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick;
      test_reset();
      test_start_timing();
      test_overflow();
      test_underrun_halt();
      test_timeout_restart();
      test_push_pop_same_cycle();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
